// File: rtl/bp_cce_hybrid_mem_cmd_arbiter.sv
// Round-robin arbiter that merges several hybrid-CCE mem_cmd streams onto one port.
// The grant is held from a message's first offered beat until its last beat handshakes.
module bp_cce_hybrid_mem_cmd_arbiter #(
  parameter int num_req_p        = 2,
  parameter int mem_data_width_p = 64,
  parameter int hdr_w            = 64
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [num_req_p*hdr_w-1:0]           req_header_i,
  input  logic [num_req_p*mem_data_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]                 req_v_i,
  input  logic [num_req_p-1:0]                 req_last_i,
  output logic [num_req_p-1:0]                 req_ready_and_o,
  output logic [hdr_w-1:0]                     mem_cmd_header_o,
  output logic [mem_data_width_p-1:0]          mem_cmd_data_o,
  output logic                                 mem_cmd_v_o,
  output logic                                 mem_cmd_last_o,
  input  logic                                 mem_cmd_ready_and_i,
  output logic [num_req_p-1:0]                 grant_o,
  output logic                                 empty_o
);

  localparam int ptr_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  // Valid/ready: a beat transfers in any cycle where mem_cmd_v_o and
  // mem_cmd_ready_and_i are both high; once offered, a beat is never withdrawn.
  logic             lock_q, lock_d;
  logic [ptr_w-1:0] owner_q, owner_d;
  logic [ptr_w-1:0] rr_ptr_q, rr_ptr_d;
  logic [ptr_w-1:0] cand;
  logic             cand_v;
  logic             hs;

  // Circular priority scan from rr_ptr_q; descending k so the nearest valid wins.
  always_comb begin : pick
    int idx;
    cand   = rr_ptr_q;
    cand_v = 1'b0;
    idx    = 0;
    if (lock_q) begin
      cand   = owner_q;
      cand_v = 1'b1;
    end else begin
      for (int k = num_req_p - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr_q) + k) % num_req_p;
        if (req_v_i[idx]) begin
          cand   = ptr_w'(idx);
          cand_v = 1'b1;
        end
      end
    end
  end

  always_comb begin : out_mux
    mem_cmd_header_o = '0;
    mem_cmd_data_o   = '0;
    mem_cmd_last_o   = 1'b0;
    mem_cmd_v_o      = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (cand == ptr_w'(i)) begin
        mem_cmd_header_o = req_header_i[i*hdr_w +: hdr_w];
        mem_cmd_data_o   = req_data_i[i*mem_data_width_p +: mem_data_width_p];
        mem_cmd_last_o   = req_last_i[i];
        mem_cmd_v_o      = cand_v & req_v_i[i];
      end
    end
  end

  assign grant_o         = cand_v ? (num_req_p'(1) << cand) : '0;
  assign req_ready_and_o = cand_v ? (num_req_p'(mem_cmd_ready_and_i) << cand) : '0;
  assign empty_o         = ~lock_q & ~(|req_v_i);
  assign hs              = mem_cmd_v_o & mem_cmd_ready_and_i;

  always_comb begin : next_state
    lock_d   = lock_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (hs && mem_cmd_last_o) begin
      lock_d   = 1'b0;
      rr_ptr_d = (cand == ptr_w'(num_req_p - 1)) ? '0 : cand + 1'b1;
    end else if (hs || (mem_cmd_v_o && !lock_q)) begin
      lock_d  = 1'b1;
      owner_d = cand;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_q   <= 1'b0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_bp_cce_hybrid_mem_cmd_arbiter.sv
// Directed bench for the mem_cmd arbiter: 2-requester instance with a beat
// scoreboard, plus a 3-requester instance for pointer wrap and async reset.
module tb_bp_cce_hybrid_mem_cmd_arbiter;

  localparam int DW = 16;
  localparam int HW = 8;
  localparam int EW = 2 + 1 + HW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // two-requester instance
  logic            reset_n;
  logic [2*HW-1:0] req_header;
  logic [2*DW-1:0] req_data;
  logic [1:0]      req_v, req_last, req_ready;
  logic [HW-1:0]   mem_hdr;
  logic [DW-1:0]   mem_data;
  logic            mem_v, mem_last, mem_ready;
  logic [1:0]      grant;
  logic            empty;

  // three-requester instance
  logic            reset_n3;
  logic [3*HW-1:0] r3_header;
  logic [3*DW-1:0] r3_data;
  logic [2:0]      r3_v, r3_last, r3_ready_o;
  logic [HW-1:0]   m3_hdr;
  logic [DW-1:0]   m3_data;
  logic            m3_v, m3_last, m3_ready;
  logic [2:0]      grant3;
  logic            empty3;

  bp_cce_hybrid_mem_cmd_arbiter #(.num_req_p(2), .mem_data_width_p(DW), .hdr_w(HW)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_header_i(req_header), .req_data_i(req_data), .req_v_i(req_v),
    .req_last_i(req_last), .req_ready_and_o(req_ready),
    .mem_cmd_header_o(mem_hdr), .mem_cmd_data_o(mem_data), .mem_cmd_v_o(mem_v),
    .mem_cmd_last_o(mem_last), .mem_cmd_ready_and_i(mem_ready),
    .grant_o(grant), .empty_o(empty)
  );

  bp_cce_hybrid_mem_cmd_arbiter #(.num_req_p(3), .mem_data_width_p(DW), .hdr_w(HW)) dut3 (
    .clk_i(clk), .reset_n_i(reset_n3),
    .req_header_i(r3_header), .req_data_i(r3_data), .req_v_i(r3_v),
    .req_last_i(r3_last), .req_ready_and_o(r3_ready_o),
    .mem_cmd_header_o(m3_hdr), .mem_cmd_data_o(m3_data), .mem_cmd_v_o(m3_v),
    .mem_cmd_last_o(m3_last), .mem_cmd_ready_and_i(m3_ready),
    .grant_o(grant3), .empty_o(empty3)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic lst, input logic [HW-1:0] h,
                      input logic [DW-1:0] d);
    exp_q.push_back({g, lst, h, d});
  endtask

  // Drive one cycle of stimulus just after posedge, then wait to the sampling edge.
  task automatic drive(input logic [1:0] v, input logic [1:0] lst,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic rdy);
    @(posedge clk); #1;
    req_v = v; req_last = lst; req_data = {d1, d0}; mem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic drive3(input logic [2:0] v, input logic [2:0] lst, input logic rdy);
    @(posedge clk); #1;
    r3_v = v; r3_last = lst; m3_ready = rdy;
    @(negedge clk);
  endtask

  // Monitor: every accepted beat of the 2-requester instance is popped and compared.
  always @(negedge clk) begin
    logic [EW-1:0] got;
    if (reset_n && mem_v && mem_ready) begin
      got = {grant, mem_last, mem_hdr, mem_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got %0h expected nothing at %0t", got, $time);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL beat_data: got %0h expected %0h at %0t", got, e, $time);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; reset_n3 = 1'b0;
    req_header = {8'hC1, 8'hC0}; req_data = '0; req_v = 2'b10; req_last = '0; mem_ready = 1'b1;
    r3_header = {8'hC2, 8'hC1, 8'hC0}; r3_data = {16'h3002, 16'h3001, 16'h3000};
    r3_v = '0; r3_last = '0; m3_ready = 1'b1;
    #12;
    // In reset the output follows the lowest-index valid requester.
    chk("rst_grant", 32'(grant), 32'h2);
    chk("rst_v", 32'(mem_v), 32'h1);
    chk("rst_empty_busy", 32'(empty), 32'h0);
    req_v = 2'b00; #1;
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_grant_idle", 32'(grant), 32'h0);
    chk("rst_ptr", 32'(dut.rr_ptr_q), 32'h0);
    @(negedge clk); reset_n = 1'b1; reset_n3 = 1'b1;

    // single-beat uc_rd from req0, same-cycle transfer, no lock
    drive(2'b01, 2'b01, 16'hA000, 16'h0, 1'b1); push(2'b01, 1'b1, 8'hC0, 16'hA000);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_v", 32'(mem_v), 32'h1);
    chk("t1_ready", 32'(req_ready), 32'h1);
    drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b1);
    chk("t1_ptr", 32'(dut.rr_ptr_q), 32'h1);
    chk("t1_lock", 32'(dut.lock_q), 32'h0);

    // req1 single beat moves the pointer back to 0
    drive(2'b10, 2'b10, 16'h0, 16'hB001, 1'b1); push(2'b10, 1'b1, 8'hC1, 16'hB001);
    chk("t1b_grant", 32'(grant), 32'h2);

    // 4-beat uc_wr from req0 with req1 waiting throughout
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, {1'b1, k == 3}, 16'hA100 + 16'(k), 16'hB100, 1'b1);
      push(2'b01, k == 3, 8'hC0, 16'hA100 + 16'(k));
      chk("t2_grant_burst", 32'(grant), 32'h1);
    end
    drive(2'b10, 2'b10, 16'h0, 16'hB100, 1'b1); push(2'b10, 1'b1, 8'hC1, 16'hB100);
    chk("t2_grant_next", 32'(grant), 32'h2);

    // both continuously valid with single-beat messages: grants alternate
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 2'b11, 16'hA200 + 16'(k), 16'hB200 + 16'(k), 1'b1);
      if (k % 2 == 0) push(2'b01, 1'b1, 8'hC0, 16'hA200 + 16'(k));
      else            push(2'b10, 1'b1, 8'hC1, 16'hB200 + 16'(k));
      chk("t3_alternate", 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h2);
    end

    // req1 stalled by downstream for 3 cycles; req0 arrives in cycle 2
    drive(2'b10, 2'b10, 16'h0, 16'hB300, 1'b0);
    chk("t4_grant_c1", 32'(grant), 32'h2);
    chk("t4_ready_c1", 32'(req_ready), 32'h0);
    for (int k = 0; k < 2; k++) begin
      drive(2'b11, 2'b11, 16'hA300, 16'hB300, 1'b0);
      chk("t4_grant_hold", 32'(grant), 32'h2);
      chk("t4_data_hold", 32'(mem_data), 32'hB300);
      chk("t4_v_hold", 32'(mem_v), 32'h1);
    end
    drive(2'b11, 2'b11, 16'hA300, 16'hB300, 1'b1); push(2'b10, 1'b1, 8'hC1, 16'hB300);
    chk("t4_release", 32'(grant), 32'h2);
    drive(2'b01, 2'b01, 16'hA300, 16'h0, 1'b1); push(2'b01, 1'b1, 8'hC0, 16'hA300);
    chk("t4_req0_after", 32'(grant), 32'h1);

    // pointer now 1: a req1 beat returns it to 0, then a 2-beat req0 message with a bubble
    drive(2'b10, 2'b10, 16'h0, 16'hB400, 1'b1); push(2'b10, 1'b1, 8'hC1, 16'hB400);
    drive(2'b11, 2'b10, 16'hA400, 16'hB401, 1'b1); push(2'b01, 1'b0, 8'hC0, 16'hA400);
    chk("t5_first", 32'(grant), 32'h1);
    for (int k = 0; k < 2; k++) begin
      drive(2'b10, 2'b10, 16'h0, 16'hB401, 1'b1);
      chk("t5_gap_v", 32'(mem_v), 32'h0);
      chk("t5_gap_ready1", 32'(req_ready[1]), 32'h0);
      chk("t5_gap_grant", 32'(grant), 32'h1);
    end
    drive(2'b11, 2'b11, 16'hA401, 16'hB401, 1'b1); push(2'b01, 1'b1, 8'hC0, 16'hA401);
    chk("t5_resume", 32'(grant), 32'h1);
    drive(2'b10, 2'b10, 16'h0, 16'hB401, 1'b1); push(2'b10, 1'b1, 8'hC1, 16'hB401);
    chk("t5_req1", 32'(grant), 32'h2);
    drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b1);

    // three requesters: pointer wrap, then async reset mid-message of req2
    drive3(3'b010, 3'b010, 1'b1);
    chk("t6_grant1", 32'(grant3), 32'h2);
    drive3(3'b000, 3'b000, 1'b1);
    chk("t6_ptr2", 32'(dut3.rr_ptr_q), 32'h2);
    drive3(3'b100, 3'b100, 1'b1);
    chk("t6_grant2", 32'(grant3), 32'h4);
    drive3(3'b000, 3'b000, 1'b1);
    chk("t6_ptr_wrap", 32'(dut3.rr_ptr_q), 32'h0);
    drive3(3'b100, 3'b000, 1'b1);
    chk("t6_beat0", 32'(grant3), 32'h4);
    drive3(3'b110, 3'b100, 1'b0);
    chk("t6_locked_grant", 32'(grant3), 32'h4);
    chk("t6_locked", 32'(dut3.lock_q), 32'h1);
    #2 reset_n3 = 1'b0;
    #1;
    chk("t6_rst_lock", 32'(dut3.lock_q), 32'h0);
    chk("t6_rst_ptr", 32'(dut3.rr_ptr_q), 32'h0);
    chk("t6_rst_grant", 32'(grant3), 32'h2);
    chk("t6_rst_v", 32'(m3_v), 32'h1);
    chk("t6_rst_empty_busy", 32'(empty3), 32'h0);
    r3_v = 3'b000; #1;
    chk("t6_rst_empty", 32'(empty3), 32'h1);
    reset_n3 = 1'b1;

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
